// File: rtl/door_timeout_ctrl.sv
// door_timeout_ctrl: door-open watchdog with pre-timeout warning, timeout and obstruction nudge mode.
module door_timeout_ctrl #(
    parameter int CNT_W       = 10,
    parameter int TIMEOUT_DEF = 10,
    parameter int WARN_LEAD   = 3,
    parameter int MAX_REOPEN  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       estado,
    input  logic [CNT_W-1:0] limit,
    input  logic             limit_ld,
    input  logic             obstruct,
    output logic             warn,
    output logic             timeout,
    output logic             nudge,
    output logic [CNT_W-1:0] count,
    output logic [2:0]       reopen_cnt
);
    typedef enum logic [1:0] {
        CLOSED_S  = 2'b00,
        OPEN_S    = 2'b01,
        WARN_S    = 2'b10,
        EXPIRED_S = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] THR_DEF = CNT_W'(TIMEOUT_DEF);
    localparam logic [CNT_W+1:0] LEAD    = (CNT_W+2)'(WARN_LEAD);
    localparam logic [2:0]       MAX_R   = 3'(MAX_REOPEN);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d, thr_q, thr_d, count_inc;
    logic [2:0]       reopen_q, reopen_d, reopen_inc;
    logic             nudge_q, nudge_d, obstruct_q, warn_n, timeout_n;

    always_comb begin
        count_inc  = (&count_q) ? count_q : count_q + CNT_W'(1);
        timeout_n  = count_inc >= thr_q;
        warn_n     = ({2'b00, count_inc} + LEAD) >= {2'b00, thr_q};
        reopen_inc = (reopen_q == MAX_R) ? reopen_q : reopen_q + 3'd1;
        thr_d      = limit_ld ? ((limit == '0) ? THR_DEF : limit) : thr_q;
        state_d    = CLOSED_S;
        count_d    = '0;
        reopen_d   = reopen_q;
        nudge_d    = nudge_q;
        if (estado != 2'b01) begin
            if (estado == 2'b00) begin
                reopen_d = '0;
                nudge_d  = 1'b0;
            end
        end else if (!nudge_q && obstruct) begin
            // a held obstruction pins the count at zero; only its rising edge counts as a re-open
            state_d = OPEN_S;
            if (!obstruct_q) begin
                reopen_d = reopen_inc;
                nudge_d  = reopen_inc == MAX_R;
            end
        end else begin
            count_d = count_inc;
            state_d = timeout_n ? EXPIRED_S : warn_n ? WARN_S : OPEN_S;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= CLOSED_S;
            count_q    <= '0;
            thr_q      <= THR_DEF;
            reopen_q   <= '0;
            nudge_q    <= 1'b0;
            obstruct_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            thr_q      <= thr_d;
            reopen_q   <= reopen_d;
            nudge_q    <= nudge_d;
            obstruct_q <= obstruct;
        end
    end

    // expiry implies warning, so both flags decode straight from the state register
    assign warn       = state_q[1];
    assign timeout    = &state_q;
    assign nudge      = nudge_q;
    assign count      = count_q;
    assign reopen_cnt = reopen_q;
endmodule

// File: tb/tb_door_timeout_ctrl.sv
// tb_door_timeout_ctrl: scoreboard bench for door_timeout_ctrl with directed and random stimulus.
module tb_door_timeout_ctrl;
    localparam int CNT_W = 10, DEF = 10, LEAD = 3, MAXR = 3, CMAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0, rst_n = 1'b0, limit_ld = 1'b0, obstruct = 1'b0;
    logic [1:0]       estado = 2'b00;
    logic [CNT_W-1:0] limit = '0;
    logic             warn, timeout, nudge;
    logic [CNT_W-1:0] count;
    logic [2:0]       reopen_cnt;

    always #5 clk = ~clk;

    door_timeout_ctrl #(.CNT_W(CNT_W), .TIMEOUT_DEF(DEF), .WARN_LEAD(LEAD), .MAX_REOPEN(MAXR)) dut (
        .clk(clk), .rst_n(rst_n), .estado(estado), .limit(limit), .limit_ld(limit_ld),
        .obstruct(obstruct), .warn(warn), .timeout(timeout), .nudge(nudge),
        .count(count), .reopen_cnt(reopen_cnt)
    );

    typedef struct packed {
        logic             w, t, n;
        logic [2:0]       r;
        logic [CNT_W-1:0] c;
    } exp_t;

    exp_t sb[$];
    int   tests = 0, fails = 0;
    int   m_cnt = 0, m_thr = DEF, m_reo = 0;
    bit   m_w = 0, m_t = 0, m_n = 0, m_pobs = 0;

    task automatic step(input bit rn, input int est, input bit obs, input bit ld = 0, input int lim = 0);
        int   nthr;
        exp_t e;
        @(negedge clk);
        rst_n = rn; estado = 2'(est); obstruct = obs; limit_ld = ld; limit = CNT_W'(lim);
        if (!rn) begin
            m_cnt = 0; m_w = 0; m_t = 0; m_n = 0; m_reo = 0; m_thr = DEF; m_pobs = 0;
        end else begin
            nthr = ld ? ((lim == 0) ? DEF : lim) : m_thr;
            if (est != 1) begin
                m_cnt = 0; m_w = 0; m_t = 0;
                if (est == 0) begin m_reo = 0; m_n = 0; end
            end else if (!m_n && obs) begin
                m_cnt = 0; m_w = 0; m_t = 0;
                if (!m_pobs) begin
                    m_reo = (m_reo < MAXR) ? m_reo + 1 : MAXR;
                    m_n = (m_reo == MAXR);
                end
            end else begin
                m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
                m_t = m_cnt >= m_thr;
                m_w = m_cnt + LEAD >= m_thr;
            end
            m_pobs = obs;
            m_thr = nthr;
        end
        e = '{m_w, m_t, m_n, 3'(m_reo), CNT_W'(m_cnt)};
        sb.push_back(e);
    endtask

    initial begin
        exp_t e, g;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                g = '{warn, timeout, nudge, reopen_cnt, count};
                tests++;
                if (g !== e) begin
                    fails++;
                    $display("FAIL out@%0t: got w%0b t%0b n%0b r%0d c%0d, want w%0b t%0b n%0b r%0d c%0d",
                             $time, g.w, g.t, g.n, g.r, g.c, e.w, e.t, e.n, e.r, e.c);
                end
            end
        end
    end

    initial begin
        int  est;
        bit  obs = 0;
        step(0, 0, 0); step(0, 0, 0);
        repeat (12) step(1, 1, 0);
        step(1, 0, 0);
        step(1, 0, 0, 1, 4);
        repeat (6) step(1, 1, 0);
        step(1, 0, 0, 1, 0);
        repeat (11) step(1, 1, 0);
        step(1, 0, 0);
        repeat (4) begin
            repeat (5) step(1, 1, 0);
            step(1, 1, 1);
        end
        repeat (12) step(1, 1, 0);
        step(1, 0, 0);
        step(1, 1, 0);
        repeat (20) step(1, 1, 1);
        repeat (3) step(1, 1, 0);
        step(1, 0, 0);
        repeat (3) begin step(1, 1, 1); step(1, 1, 0); end
        repeat (1030) step(1, 1, 0);
        step(1, 2, 0);
        repeat (3) step(1, 1, 0);
        step(1, 3, 0);
        step(1, 1, 0);
        step(1, 0, 0);
        repeat (3) begin step(1, 1, 1); step(1, 1, 0); end
        step(1, 1, 0, 1, 30);
        repeat (12) step(1, 1, 0);
        step(0, 1, 0);
        repeat (11) step(1, 1, 0);
        step(1, 0, 0);
        repeat (4000) begin
            case ($urandom_range(0, 19))
                0:       est = 0;
                1:       est = 2;
                2:       est = 3;
                default: est = 1;
            endcase
            if ($urandom_range(0, 14) == 0) obs = ~obs;
            step($urandom_range(0, 199) != 0, est, obs, $urandom_range(0, 29) == 0, int'($urandom_range(0, 20)));
        end
        repeat (3) @(posedge clk);
        #2;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
